// File: rtl/demux_1to3_reg_pkg.sv
// Shared select encodings and drop-counter constants for demux_1to3_reg.
package demux_1to3_reg_pkg;

    localparam logic [1:0] SEL_CH0     = 2'b00;
    localparam logic [1:0] SEL_CH1     = 2'b01;
    localparam logic [1:0] SEL_CH2     = 2'b10;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    localparam int unsigned NUM_CH     = 3;
    localparam int unsigned DROP_CNT_W = 8;

    // Saturating increment used by the optional drop counter.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// Single-entry output slot: loads one beat, holds it until the consumer takes it.
module demux_out_slot #(
    parameter int unsigned size = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [size-1:0] load_data,
    input  logic            ready,
    output logic            valid,
    output logic [size-1:0] data,
    output logic            can_accept
);

    logic            valid_q, valid_d;
    logic [size-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q & ~ready;
        data_d  = data_q;
        // A load wins over a drain so a full slot can refill in the same cycle.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid      = valid_q;
    assign data       = data_q;
    assign can_accept = ~valid_q | ready;

endmodule

// File: rtl/demux_1to3_reg.sv
// Registered 1-to-3 demultiplexer with valid/ready handshakes and a sticky illegal-select flag.
// Define DEMUX_DROP_CNT_EN to add drop_cnt_o, a saturating count of discarded select-11 beats.
module demux_1to3_reg
    import demux_1to3_reg_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [size-1:0]       data_i,
    input  logic [1:0]            select_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [size-1:0]       data0_o,
    output logic [size-1:0]       data1_o,
    output logic [size-1:0]       data2_o,
    output logic                  valid0_o,
    output logic                  valid1_o,
    output logic                  valid2_o,
    input  logic                  ready0_i,
    input  logic                  ready1_i,
    input  logic                  ready2_i,
`ifdef DEMUX_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt_o,
`endif
    output logic                  err_o
);

    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] can_accept;
    logic              accept;
    logic              drop;
    logic              err_q;

    // Illegal beats are always taken so upstream never stalls on a bad select.
    always_comb begin
        ready_o = 1'b1;
        case (select_i)
            SEL_CH0: ready_o = can_accept[0];
            SEL_CH1: ready_o = can_accept[1];
            SEL_CH2: ready_o = can_accept[2];
            default: ready_o = 1'b1;
        endcase
    end

    assign accept  = valid_i & ready_o;
    assign load[0] = accept & (select_i == SEL_CH0);
    assign load[1] = accept & (select_i == SEL_CH1);
    assign load[2] = accept & (select_i == SEL_CH2);
    assign drop    = accept & (select_i == SEL_ILLEGAL);

    demux_out_slot #(
        .size (size)
    ) u_slot0 (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .load       (load[0]),
        .load_data  (data_i),
        .ready      (ready0_i),
        .valid      (valid0_o),
        .data       (data0_o),
        .can_accept (can_accept[0])
    );

    demux_out_slot #(
        .size (size)
    ) u_slot1 (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .load       (load[1]),
        .load_data  (data_i),
        .ready      (ready1_i),
        .valid      (valid1_o),
        .data       (data1_o),
        .can_accept (can_accept[1])
    );

    demux_out_slot #(
        .size (size)
    ) u_slot2 (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .load       (load[2]),
        .load_data  (data_i),
        .ready      (ready2_i),
        .valid      (valid2_o),
        .data       (data2_o),
        .can_accept (can_accept[2])
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else if (drop) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

`ifdef DEMUX_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_1to3_reg.sv
// Scoreboard bench for demux_1to3_reg: per-channel expected-beat queues checked at each negedge.
module tb_demux_1to3_reg;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [W-1:0]  data_i;
    logic [1:0]    select_i;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  data0_o, data1_o, data2_o;
    logic          valid0_o, valid1_o, valid2_o;
    logic [2:0]    rdy;
    logic          err_o;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0]    drop_cnt_o;
`endif

    demux_1to3_reg #(
        .size (W)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .select_i (select_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data0_o  (data0_o),
        .data1_o  (data1_o),
        .data2_o  (data2_o),
        .valid0_o (valid0_o),
        .valid1_o (valid1_o),
        .valid2_o (valid2_o),
        .ready0_i (rdy[0]),
        .ready1_i (rdy[1]),
        .ready2_i (rdy[2]),
`ifdef DEMUX_DROP_CNT_EN
        .drop_cnt_o (drop_cnt_o),
`endif
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    logic [W-1:0] dout [3];
    logic [2:0]   vout;
    assign dout[0] = data0_o;
    assign dout[1] = data1_o;
    assign dout[2] = data2_o;
    assign vout    = {valid2_o, valid1_o, valid0_o};

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    // Reference model: beats waiting per channel, last value seen per channel, error/drop state.
    logic [W-1:0] q [3][$];
    logic [W-1:0] last [3];
    bit           err_m;
    int           drop_m;
    bit           exp_rdy;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            last[k] = '0;
        end
        err_m  = 1'b0;
        drop_m = 0;
    endtask

    task automatic drive(input bit v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [2:0] r);
        @(posedge clk);
        #1;
        valid_i  = v;
        select_i = s;
        data_i   = d;
        rdy      = r;
    endtask

    // Monitor: compare DUT against model, retire drained beats, then record accepted beats.
    always @(negedge clk) begin
        if (mon_en && rst_i) begin
            if (select_i == 2'b11) exp_rdy = 1'b1;
            else exp_rdy = (q[select_i].size() == 0) || rdy[select_i];
            check("ready_o", {31'b0, ready_o}, {31'b0, exp_rdy});
            check("err_o", {31'b0, err_o}, {31'b0, err_m});
`ifdef DEMUX_DROP_CNT_EN
            check("drop_cnt_o", {24'b0, drop_cnt_o}, W'(drop_m));
`endif
            for (int k = 0; k < 3; k++) begin
                check($sformatf("valid%0d_o", k), {31'b0, vout[k]},
                      {31'b0, (q[k].size() != 0)});
                check($sformatf("data%0d_o", k), dout[k], last[k]);
                if (q[k].size() != 0 && rdy[k]) begin
                    check($sformatf("drain%0d", k), dout[k], q[k][0]);
                    void'(q[k].pop_front());
                end
            end
            if (valid_i && exp_rdy) begin
                if (select_i == 2'b11) begin
                    err_m = 1'b1;
                    if (drop_m < 255) drop_m++;
                end else begin
                    q[select_i].push_back(data_i);
                    last[select_i] = data_i;
                end
            end
        end
    end

    initial begin
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        select_i = 2'b00;
        data_i   = '0;
        rdy      = 3'b000;
        reset_model();
        #2 rst_i = 1'b0;
        #10;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_valid%0d", k), {31'b0, vout[k]}, '0);
            check($sformatf("rst_data%0d", k), dout[k], '0);
        end
        check("rst_err", {31'b0, err_o}, '0);
        for (int s = 0; s < 4; s++) begin
            select_i = 2'(s);
            #1;
            check("rst_ready", {31'b0, ready_o}, 32'd1);
        end
        @(posedge clk);
        #1;
        rst_i  = 1'b1;
        mon_en = 1'b1;

        // Idle: every select shows ready, nothing changes without valid_i.
        for (int s = 0; s < 4; s++) drive(1'b0, 2'(s), $urandom, 3'b000);

        // Single beat to ch1.
        drive(1'b1, 2'b01, 32'hDEADBEEF, 3'b010);
        drive(1'b0, 2'b00, '0, 3'b010);
        drive(1'b0, 2'b00, '0, 3'b010);

        // Backpressure on ch2, then simultaneous drain and load.
        drive(1'b1, 2'b10, 32'hAAAA_0001, 3'b000);
        drive(1'b1, 2'b10, 32'hBBBB_0002, 3'b000);
        drive(1'b1, 2'b10, 32'hBBBB_0002, 3'b000);
        drive(1'b1, 2'b10, 32'hBBBB_0002, 3'b100);
        drive(1'b0, 2'b00, '0, 3'b100);
        drive(1'b0, 2'b00, '0, 3'b000);

        // Full-throughput streaming on ch0.
        for (int i = 1; i <= 8; i++) drive(1'b1, 2'b00, W'(i), 3'b001);
        drive(1'b0, 2'b00, '0, 3'b001);

        // Illegal select, then enough to saturate the drop counter.
        drive(1'b1, 2'b11, 32'h1234_5678, 3'b000);
        drive(1'b0, 2'b11, '0, 3'b000);
        drive(1'b0, 2'b00, '0, 3'b000);
        for (int i = 0; i < 300; i++) drive(1'b1, 2'b11, $urandom, 3'($urandom_range(0, 7)));
        drive(1'b0, 2'b00, '0, 3'b000);
        drive(1'b0, 2'b00, '0, 3'b000);

        // Asynchronous reset while ch0 is holding a stalled beat.
        drive(1'b1, 2'b00, 32'hC0FF_EE00, 3'b000);
        drive(1'b0, 2'b00, '0, 3'b000);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst_valid0", {31'b0, valid0_o}, '0);
        check("async_rst_data0", data0_o, '0);
        check("async_rst_err", {31'b0, err_o}, '0);
        reset_model();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        drive(1'b1, 2'b00, 32'h0000_0055, 3'b000);
        drive(1'b0, 2'b00, '0, 3'b001);
        drive(1'b0, 2'b00, '0, 3'b000);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), (r == 0) ? 2'b11 : 2'(r % 3), $urandom,
                  3'($urandom_range(0, 7)));
        end
        drive(1'b0, 2'b00, '0, 3'b111);
        drive(1'b0, 2'b00, '0, 3'b111);
        drive(1'b0, 2'b00, '0, 3'b000);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
